// File: rtl/lockin_channel_scheduler.sv
// Round-robin scheduler sharing one banked lock-in engine between NCH ADS1299 channels.
// Define LOCKIN_SCHED_TIMEOUT_EN to abort a WAIT after TIMEOUT clk and raise sticky timeout_err.
module lockin_channel_scheduler #(
    parameter int NCH     = 8,
    parameter int Q_in    = 24,
    parameter int Q_out   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [NCH*Q_in-1:0]      ch_x,
    input  logic [NCH-1:0]           ch_valid,
    input  logic                     clear_ovf,
    output logic [Q_in-1:0]          eng_x,
    output logic [$clog2(NCH)-1:0]   eng_ch,
    output logic                     eng_x_valid,
    input  logic [Q_out-1:0]         eng_fase,
    input  logic [Q_out-1:0]         eng_cuad,
    input  logic                     eng_valid,
    output logic [Q_out-1:0]         out_fase,
    output logic [Q_out-1:0]         out_cuad,
    output logic [$clog2(NCH)-1:0]   out_ch,
    output logic                     out_valid,
    output logic [NCH-1:0]           overflow,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int CHW = $clog2(NCH);

    // Strobe protocol: every *_valid is a 1-clk pulse with no back-pressure. Channel strobes are
    // latched in hold/pending; the engine takes eng_x_valid unconditionally and answers with one eng_valid.

    if (NCH < 2 || TIMEOUT < 1) begin : g_param_check
        $error("lockin_channel_scheduler: NCH must be >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t          state;
    logic [NCH-1:0]  pending;
    logic [Q_in-1:0] hold [NCH];
    logic [CHW-1:0]  ptr;

    logic            grant_found;
    logic [CHW-1:0]  grant_idx;
    logic            grant_fire;
    logic [NCH-1:0]  grant_vec;

    function automatic logic [CHW-1:0] wrap_add(input logic [CHW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= 32'(NCH)) s = s - 32'(NCH);
        return s[CHW-1:0];
    endfunction

    // Walk downward so the smallest offset from ptr is the last (winning) assignment.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (pending[wrap_add(ptr, i)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_add(ptr, i);
            end
        end
    end

    assign grant_fire = (state == S_IDLE) && enable && grant_found;

    always_comb begin
        grant_vec = '0;
        if (grant_fire) grant_vec[grant_idx] = 1'b1;
    end

    // A strobe landing on the grant clk refills hold and keeps pending; the grant uses the old hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending  <= '0;
            overflow <= '0;
            for (int i = 0; i < NCH; i++) hold[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (ch_valid[i]) begin
                    hold[i]    <= ch_x[i*Q_in +: Q_in];
                    pending[i] <= 1'b1;
                end else if (grant_vec[i]) begin
                    pending[i] <= 1'b0;
                end
                if (ch_valid[i] && pending[i] && !grant_vec[i]) overflow[i] <= 1'b1;
                else if (clear_ovf)                             overflow[i] <= 1'b0;
            end
        end
    end

`ifdef LOCKIN_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            ptr         <= '0;
            eng_x       <= '0;
            eng_ch      <= '0;
            eng_x_valid <= 1'b0;
            out_fase    <= '0;
            out_cuad    <= '0;
            out_ch      <= '0;
            out_valid   <= 1'b0;
`ifdef LOCKIN_SCHED_TIMEOUT_EN
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            eng_x_valid <= 1'b0;
            out_valid   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_fire) begin
                        eng_x  <= hold[grant_idx];
                        eng_ch <= grant_idx;
                        ptr    <= wrap_add(grant_idx, 1);
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    eng_x_valid <= 1'b1;
                    state       <= S_WAIT;
`ifdef LOCKIN_SCHED_TIMEOUT_EN
                    wait_cnt    <= '0;
`endif
                end
                S_WAIT: begin
                    if (eng_valid) begin
                        out_fase  <= eng_fase;
                        out_cuad  <= eng_cuad;
                        out_ch    <= eng_ch;
                        out_valid <= 1'b1;
                        state     <= S_IDLE;
                    end
`ifdef LOCKIN_SCHED_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_lockin_channel_scheduler.sv
// Bench for lockin_channel_scheduler: engine BFM answering 9 clk after issue, issue/result scoreboards.
// Build with +define+LOCKIN_SCHED_TIMEOUT_EN to also exercise the engine timeout path.
module tb_lockin_channel_scheduler;

    localparam int NCH = 8;
    localparam int QI  = 24;
    localparam int QO  = 32;
    localparam int CHW = 3;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                enable;
    logic [NCH*QI-1:0]   ch_x;
    logic [NCH-1:0]      ch_valid;
    logic                clear_ovf;
    logic [QI-1:0]       eng_x;
    logic [CHW-1:0]      eng_ch;
    logic                eng_x_valid;
    logic [QO-1:0]       eng_fase;
    logic [QO-1:0]       eng_cuad;
    logic                eng_valid;
    logic [QO-1:0]       out_fase;
    logic [QO-1:0]       out_cuad;
    logic [CHW-1:0]      out_ch;
    logic                out_valid;
    logic [NCH-1:0]      overflow;
    logic                busy;
    logic                timeout_err;

    lockin_channel_scheduler #(.NCH(NCH), .Q_in(QI), .Q_out(QO), .TIMEOUT(64)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .ch_x(ch_x), .ch_valid(ch_valid),
        .clear_ovf(clear_ovf), .eng_x(eng_x), .eng_ch(eng_ch), .eng_x_valid(eng_x_valid),
        .eng_fase(eng_fase), .eng_cuad(eng_cuad), .eng_valid(eng_valid),
        .out_fase(out_fase), .out_cuad(out_cuad), .out_ch(out_ch), .out_valid(out_valid),
        .overflow(overflow), .busy(busy), .timeout_err(timeout_err)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_issue  = 0;
    int n_out    = 0;
    int bfm_cnt  = 0;
    logic bfm_silent = 1'b0;
    logic bfm_fixed  = 1'b0;
    logic prev_exv   = 1'b0;
    logic prev_ov    = 1'b0;
    logic [QI-1:0]  bfm_x;
    logic [CHW-1:0] bfm_ch;

    logic [CHW+QI-1:0]   iss_q[$];
    logic [CHW+2*QO-1:0] res_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // engine model: fase = 2*x + ch, cuad = -x - 1 (sign-extended sample)
    function automatic logic [2*QO-1:0] model(input logic [CHW-1:0] ch, input logic [QI-1:0] x);
        logic [QO-1:0] xs, f, c;
        xs = {{(QO-QI){x[QI-1]}}, x};
        f  = (xs << 1) + {{(QO-CHW){1'b0}}, ch};
        c  = ~xs;
        return {f, c};
    endfunction

    // driver tasks
    task automatic set_x(input int ch, input logic [QI-1:0] v);
        ch_x[ch*QI +: QI] = v;
    endtask

    task automatic expect_op(input int ch, input logic [QI-1:0] x);
        iss_q.push_back({CHW'(ch), x});
        res_q.push_back({CHW'(ch), model(CHW'(ch), x)});
    endtask

    task automatic strobe(input logic [NCH-1:0] mask);
        @(negedge clk);
        ch_valid = mask;
        @(negedge clk);
        ch_valid = '0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset_n   = 1'b0;
        ch_valid  = '0;
        clear_ovf = 1'b0;
        iss_q.delete();
        res_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((iss_q.size() != 0 || res_q.size() != 0 || busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(n < 400), 64'd1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, {eng_x, eng_ch, eng_x_valid, out_ch, out_valid, overflow, busy, timeout_err}, 64'd0);
        check({tag, "_fase"}, out_fase, 64'd0);
        check({tag, "_cuad"}, out_cuad, 64'd0);
    endtask

    // engine BFM + scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        logic [CHW+QI-1:0]   ei;
        logic [CHW+2*QO-1:0] er;
        if (!reset_n) begin
            bfm_cnt   = 0;
            eng_valid = 1'b0;
            eng_fase  = '0;
            eng_cuad  = '0;
            prev_exv  = 1'b0;
            prev_ov   = 1'b0;
        end else begin
            eng_valid = 1'b0;
            if (bfm_cnt > 0) begin
                bfm_cnt--;
                if (bfm_cnt == 0 && !bfm_silent) begin
                    eng_valid = 1'b1;
                    if (bfm_fixed) {eng_fase, eng_cuad} = {32'd5, 32'hFFFF_FFF9};
                    else           {eng_fase, eng_cuad} = model(bfm_ch, bfm_x);
                end
            end
            if (eng_x_valid) begin
                n_issue++;
                check("exv_pulse", 64'(prev_exv), 64'd0);
                check("iss_q_avail", 64'(iss_q.size() != 0), 64'd1);
                if (iss_q.size() != 0) begin
                    ei = iss_q.pop_front();
                    check("eng_ch", 64'(eng_ch), 64'(ei[CHW+QI-1 -: CHW]));
                    check("eng_x", 64'(eng_x), 64'(ei[QI-1:0]));
                end
                bfm_cnt = 9;
                bfm_x   = eng_x;
                bfm_ch  = eng_ch;
            end
            if (out_valid) begin
                n_out++;
                check("ov_pulse", 64'(prev_ov), 64'd0);
                check("res_q_avail", 64'(res_q.size() != 0), 64'd1);
                if (res_q.size() != 0) begin
                    er = res_q.pop_front();
                    check("out_ch", 64'(out_ch), 64'(er[CHW+2*QO-1 -: CHW]));
                    check("out_fase", 64'(out_fase), 64'(er[2*QO-1 -: QO]));
                    check("out_cuad", 64'(out_cuad), 64'(er[QO-1:0]));
                end
            end
            prev_exv = eng_x_valid;
            prev_ov  = out_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, ni, no;
        logic [QI-1:0] v;
        ch_x      = '0;
        ch_valid  = '0;
        clear_ovf = 1'b0;
        enable    = 1'b1;
        reset_n   = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("rst");
        reset_n = 1'b1;

        // single request, fixed engine answer, issue latency
        bfm_fixed = 1'b1;
        set_x(3, 24'h000100);
        iss_q.push_back({3'd3, 24'h000100});
        res_q.push_back({3'd3, 32'd5, 32'hFFFF_FFF9});
        @(negedge clk);
        ch_valid = 8'h08;
        @(negedge clk);
        ch_valid = '0;
        lat = 0;
        while (!eng_x_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("t1_issue_lat", 64'(lat), 64'd2);
        drain("t1_drain");
        bfm_fixed = 1'b0;
        check("t1_eng_x_hold", 64'(eng_x), 64'h100);
        check("t1_eng_ch_hold", 64'(eng_ch), 64'd3);
        check("t1_n_out", 64'(n_out), 64'd1);

        // all channels at once from ptr = 0
        reset_dut();
        no = n_out;
        for (int i = 0; i < NCH; i++) begin
            v = QI'($urandom_range(0, 32'h00FF_FFFF));
            set_x(i, v);
            expect_op(i, v);
        end
        strobe(8'hFF);
        drain("t2_drain");
        check("t2_overflow", 64'(overflow), 64'd0);
        check("t2_n_out", 64'(n_out - no), 64'd8);

        // round-robin continues after ch5: ch6 before ch2
        reset_dut();
        set_x(5, 24'h000555);
        expect_op(5, 24'h000555);
        strobe(8'h20);
        repeat (3) @(negedge clk);
        set_x(2, 24'hFFF222);
        set_x(6, 24'h000666);
        expect_op(6, 24'h000666);
        expect_op(2, 24'hFFF222);
        strobe(8'h44);
        drain("t3_drain");

        // overwrite while engine busy
        expect_op(0, 24'h000011);
        expect_op(1, 24'd20);
        @(negedge clk); set_x(0, 24'h000011); ch_valid = 8'h01;
        @(negedge clk); set_x(1, 24'd10);     ch_valid = 8'h02;
        @(negedge clk); set_x(1, 24'd20);     ch_valid = 8'h02;
        @(negedge clk); ch_valid = '0;
        drain("t4_drain");
        check("t4_overflow", 64'(overflow), 64'h02);
        @(negedge clk); clear_ovf = 1'b1;
        @(negedge clk); clear_ovf = 1'b0;
        check("t4_clear", 64'(overflow), 64'd0);

        // strobe on the grant clk: old value issued, new one kept pending, no overflow
        expect_op(7, 24'h0000AA);
        expect_op(7, 24'h0000BB);
        @(negedge clk); set_x(7, 24'h0000AA); ch_valid = 8'h80;
        @(negedge clk); set_x(7, 24'h0000BB); ch_valid = 8'h80;
        @(negedge clk); ch_valid = '0;
        drain("t4b_drain");
        check("t4b_overflow", 64'(overflow), 64'd0);

        // new overflow beats clear_ovf in the same clk
        expect_op(0, 24'h000022);
        expect_op(1, 24'd50);
        @(negedge clk); set_x(0, 24'h000022); ch_valid = 8'h01;
        @(negedge clk); set_x(1, 24'd30);     ch_valid = 8'h02;
        @(negedge clk); set_x(1, 24'd40);     ch_valid = 8'h02;
        @(negedge clk); set_x(1, 24'd50);     ch_valid = 8'h02; clear_ovf = 1'b1;
        @(negedge clk); ch_valid = '0; clear_ovf = 1'b0;
        check("t4c_ovf_wins", 64'(overflow), 64'h02);
        drain("t4c_drain");
        @(negedge clk); clear_ovf = 1'b1;
        @(negedge clk); clear_ovf = 1'b0;
        check("t4c_clear", 64'(overflow), 64'd0);

        // enable gating
        enable = 1'b0;
        set_x(4, 24'h000444);
        expect_op(4, 24'h000444);
        strobe(8'h10);
        ni = n_issue;
        repeat (100) @(negedge clk);
        check("t5_no_issue", 64'(n_issue - ni), 64'd0);
        check("t5_idle", 64'(busy), 64'd0);
        enable = 1'b1;
        @(negedge clk);
        check("t5_grant_busy", 64'(busy), 64'd1);
        check("t5_grant_ch", 64'(eng_ch), 64'd4);
        drain("t5_drain");

`ifdef LOCKIN_SCHED_TIMEOUT_EN
        // silent engine -> abort after TIMEOUT, then normal service resumes
        reset_dut();
        no = n_out;
        bfm_silent = 1'b1;
        set_x(3, 24'h000333);
        iss_q.push_back({3'd3, 24'h000333});
        strobe(8'h08);
        repeat (30) @(negedge clk);
        check("t6_still_wait", 64'(busy), 64'd1);
        check("t6_no_err_yet", 64'(timeout_err), 64'd0);
        repeat (60) @(negedge clk);
        check("t6_timeout_err", 64'(timeout_err), 64'd1);
        check("t6_idle", 64'(busy), 64'd0);
        check("t6_no_out", 64'(n_out - no), 64'd0);
        bfm_silent = 1'b0;
        set_x(5, 24'h000505);
        expect_op(5, 24'h000505);
        strobe(8'h20);
        drain("t6_drain");
        check("t6_err_sticky", 64'(timeout_err), 64'd1);
`endif

        // reset while waiting on the engine drops the op
        ni = n_issue;
        set_x(2, 24'h000202);
        iss_q.push_back({3'd2, 24'h000202});
        strobe(8'h04);
        lat = 0;
        while (n_issue == ni && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("t7_issued", 64'(n_issue - ni), 64'd1);
        repeat (3) @(negedge clk);
        check("t7_in_wait", 64'(busy), 64'd1);
        no = n_out;
        reset_n = 1'b0;
        #1;
        check_zero("t7_rst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("t7_no_out", 64'(n_out - no), 64'd0);
        check("t7_idle", 64'(busy), 64'd0);
        check("end_iss_q", 64'(iss_q.size()), 64'd0);
        check("end_res_q", 64'(res_q.size()), 64'd0);

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
